// File: rtl/opl2_pkg.sv
// ============================================================================
//  Module      : opl2_pkg
//  Description : Shared types and constants for the OPL2 write scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package opl2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR_WR  = 3'd1,
        ST_ADDR_GAP = 3'd2,
        ST_DATA_WR  = 3'd3,
        ST_DATA_GAP = 3'd4
    } state_t;

    localparam logic [7:0] OPL_KEYON_BASE = 8'hB0;
    localparam int         OPL_NUM_CH     = 9;
    localparam logic [7:0] OPL_RHYTHM_REG = 8'hBD;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] val;
    } write_t;

    // Key-off sweep: one write per melodic channel, then the rhythm register.
    function automatic write_t silence_write(input logic [3:0] idx);
        write_t w;
        w.val = 8'h00;
        if (idx < 4'(OPL_NUM_CH))
            w.addr = OPL_KEYON_BASE + {4'h0, idx};
        else
            w.addr = OPL_RHYTHM_REG;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/opl2_silence_seq.sv
// ============================================================================
//  Module      : opl2_silence_seq
//  Description : Key-off sweep source presenting ten writes as a valid/ready requester.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opl2_silence_seq
    import opl2_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    input  logic        ready,
    output logic        valid,
    output logic [15:0] data
);

    logic       r_pending;
    logic [3:0] r_idx;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_pending <= 1'b0;
            r_idx     <= 4'd0;
        end else if (r_pending) begin
            if (ready) begin
                if (r_idx == 4'(OPL_NUM_CH)) begin
                    r_pending <= 1'b0;
                    r_idx     <= 4'd0;
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
            end
        end else if (start) begin
            r_pending <= 1'b1;
            r_idx     <= 4'd0;
        end
    end

    assign valid = r_pending;
    assign data  = silence_write(r_idx);

endmodule

`default_nettype wire

// File: rtl/opl2_write_sched.sv
// ============================================================================
//  Module      : opl2_write_sched
//  Description : Arbitrates s0/s1/silence writes into timed two-phase OPL2 bus cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opl2_write_sched
    import opl2_pkg::*;
#(
    parameter int WR_PULSE = 1,
    parameter int ADDR_GAP = 40,
    parameter int DATA_GAP = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        s0_valid,
    input  logic [15:0] s0_data,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [15:0] s1_data,
    output logic        s1_ready,
    input  logic        silence_req,
    output logic        opl_wr_n,
    output logic        opl_a0,
    output logic [7:0]  opl_din,
    output logic        busy,
    output logic        silence_busy,
    output logic [15:0] wr_count
);

    localparam int c_max_gap = (ADDR_GAP > DATA_GAP) ? ADDR_GAP : DATA_GAP;
    localparam int c_max_cnt = (c_max_gap > WR_PULSE) ? c_max_gap : WR_PULSE;
    localparam int c_cnt_w   = $clog2(c_max_cnt + 1);

    localparam logic [c_cnt_w-1:0] c_pulse_ld = c_cnt_w'(WR_PULSE - 1);
    localparam logic [c_cnt_w-1:0] c_agap_ld  = c_cnt_w'(ADDR_GAP - 1);
    localparam logic [c_cnt_w-1:0] c_dgap_ld  = c_cnt_w'(DATA_GAP - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [7:0]           r_val;
    logic                 r_cur_sil;
    logic                 r_rr_ptr;
    logic                 r_wr_n;
    logic                 r_a0;
    logic [7:0]           r_din;
    logic [15:0]          r_wr_count;

    logic                 w_sil_valid;
    logic [15:0]          w_sil_data;
    logic                 w_sil_ready;
    logic                 w_sil_start;
    logic                 w_can_accept;
    logic                 w_s0_ready;
    logic                 w_s1_ready;
    logic                 w_accept;
    write_t               w_acc;

    assign silence_busy = w_sil_valid || ((r_state != ST_IDLE) && r_cur_sil);
    assign w_sil_start  = silence_req && enable && !silence_busy;

    opl2_silence_seq u_silence_seq (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .start  (w_sil_start),
        .ready  (w_sil_ready),
        .valid  (w_sil_valid),
        .data   (w_sil_data)
    );

    // Silence sweep outranks both requesters; a lone valid requester ignores the pointer.
    assign w_can_accept = (r_state == ST_IDLE) && enable && !rst;
    assign w_sil_ready  = w_can_accept && w_sil_valid;
    assign w_s0_ready   = w_can_accept && !w_sil_valid && s0_valid && (!r_rr_ptr || !s1_valid);
    assign w_s1_ready   = w_can_accept && !w_sil_valid && s1_valid && (r_rr_ptr || !s0_valid);
    assign w_accept     = w_sil_ready || w_s0_ready || w_s1_ready;

    always_comb begin
        w_acc = write_t'(s1_data);
        if (w_sil_ready)
            w_acc = write_t'(w_sil_data);
        else if (w_s0_ready)
            w_acc = write_t'(s0_data);
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_val     <= 8'h00;
            r_cur_sil <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_wr_n    <= 1'b1;
            r_a0      <= 1'b0;
            r_din     <= 8'h00;
            if (rst)
                r_wr_count <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_val     <= w_acc.val;
                        r_cur_sil <= w_sil_ready;
                        if (w_s0_ready)
                            r_rr_ptr <= 1'b1;
                        else if (w_s1_ready)
                            r_rr_ptr <= 1'b0;
                        r_state   <= ST_ADDR_WR;
                        r_cnt     <= c_pulse_ld;
                        r_wr_n    <= 1'b0;
                        r_a0      <= 1'b0;
                        r_din     <= w_acc.addr;
                    end
                end
                ST_ADDR_WR: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_ADDR_GAP;
                        r_cnt   <= c_agap_ld;
                        r_wr_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ADDR_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DATA_WR;
                        r_cnt   <= c_pulse_ld;
                        r_wr_n  <= 1'b0;
                        r_a0    <= 1'b1;
                        r_din   <= r_val;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DATA_WR: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DATA_GAP;
                        r_cnt   <= c_dgap_ld;
                        r_wr_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DATA_GAP: begin
                    if (r_cnt == '0) begin
                        r_state    <= ST_IDLE;
                        r_cur_sil  <= 1'b0;
                        r_wr_count <= r_wr_count + 16'd1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wr_n  <= 1'b1;
                end
            endcase
        end
    end

    assign s0_ready = w_s0_ready;
    assign s1_ready = w_s1_ready;
    assign opl_wr_n = r_wr_n;
    assign opl_a0   = r_a0;
    assign opl_din  = r_din;
    assign busy     = (r_state != ST_IDLE) || w_sil_valid;
    assign wr_count = r_wr_count;

endmodule

`default_nettype wire

// File: tb/tb_opl2_write_sched.sv
// ============================================================================
//  Module      : tb_opl2_write_sched
//  Description : Directed self-checking bench for opl2_write_sched at default timing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_opl2_write_sched;

    logic        clk = 1'b0;
    logic        rst, enable, silence_req;
    logic        s0_valid, s1_valid;
    logic [15:0] s0_data, s1_data;
    logic        s0_ready, s1_ready;
    logic        opl_wr_n, opl_a0, busy, silence_busy;
    logic [7:0]  opl_din;
    logic [15:0] wr_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    opl2_write_sched dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s0_valid     (s0_valid),
        .s0_data      (s0_data),
        .s0_ready     (s0_ready),
        .s1_valid     (s1_valid),
        .s1_data      (s1_data),
        .s1_ready     (s1_ready),
        .silence_req  (silence_req),
        .opl_wr_n     (opl_wr_n),
        .opl_a0       (opl_a0),
        .opl_din      (opl_din),
        .busy         (busy),
        .silence_busy (silence_busy),
        .wr_count     (wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 2000) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    // who: 0 = s0, 1 = s1, 2 = both (illegal), -1 = none within budget
    task automatic wait_grant(output int who);
        int k = 0;
        #1;
        while (!(s0_ready || s1_ready) && k < 600) begin
            tick();
            k++;
        end
        if (s0_ready && s1_ready) who = 2;
        else if (s0_ready)        who = 0;
        else if (s1_ready)        who = 1;
        else                      who = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         who;
        int         nw;
        int         k;
        logic       bad;
        logic [7:0] regs [16];
        logic [7:0] vals [16];
        logic [15:0] wc;
        int         exp_rr [4];

        rst = 1'b1; enable = 1'b1; silence_req = 1'b0;
        s0_valid = 1'b1; s1_valid = 1'b0; s0_data = 16'h0000; s1_data = 16'h0000;
        tick(2);
        chk("rst_wr_n",     {31'd0, opl_wr_n}, 32'd1);
        chk("rst_a0",       {31'd0, opl_a0}, 32'd0);
        chk("rst_din",      {24'd0, opl_din}, 32'd0);
        chk("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        chk("rst_count",    {16'd0, wr_count}, 32'd0);
        s0_valid = 1'b0; rst = 1'b0;
        tick();

        // Single s0 write: check phase timing against handshake cycle T.
        s0_data = 16'h2001; s0_valid = 1'b1;
        #1;
        chk("t1_s0_ready_T", {31'd0, s0_ready}, 32'd1);
        chk("t1_s1_ready_T", {31'd0, s1_ready}, 32'd0);
        tick();
        chk("t1_addr_wr_n", {31'd0, opl_wr_n}, 32'd0);
        chk("t1_addr_a0",   {31'd0, opl_a0}, 32'd0);
        chk("t1_addr_din",  {24'd0, opl_din}, 32'h20);
        s0_data = 16'h2102;
        #1;
        chk("t1_ready_busy", {31'd0, s0_ready}, 32'd0);
        tick(40);
        chk("t1_gap41_wr_n", {31'd0, opl_wr_n}, 32'd1);
        chk("t1_gap41_din",  {24'd0, opl_din}, 32'h20);
        tick();
        chk("t1_data_wr_n", {31'd0, opl_wr_n}, 32'd0);
        chk("t1_data_a0",   {31'd0, opl_a0}, 32'd1);
        chk("t1_data_din",  {24'd0, opl_din}, 32'h01);
        tick(250);
        chk("t1_ready_292", {31'd0, s0_ready}, 32'd0);
        chk("t1_count_292", {16'd0, wr_count}, 32'd0);
        tick();
        chk("t1_ready_293", {31'd0, s0_ready}, 32'd1);
        chk("t1_count_293", {16'd0, wr_count}, 32'd1);
        s0_valid = 1'b0;

        // Both requesters valid: pointer sits on s1 after the s0 grant above.
        exp_rr[0] = 1; exp_rr[1] = 0; exp_rr[2] = 1; exp_rr[3] = 0;
        s0_data = 16'h3011; s1_data = 16'h3122;
        s0_valid = 1'b1; s1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_grant(who);
            chk("t2_rr_grant", who, exp_rr[i]);
            tick();
            chk("t2_addr_din", {24'd0, opl_din}, (exp_rr[i] == 0) ? 32'h30 : 32'h31);
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        wait_idle("t2_idle");
        chk("t2_count", {16'd0, wr_count}, 32'd5);

        // Silence request during an s0 write's data gap.
        wc = wr_count;
        s0_data = 16'h403F; s0_valid = 1'b1;
        #1;
        chk("t3_accept", {31'd0, s0_ready}, 32'd1);
        tick();
        s0_data = 16'h4140;
        tick(100);
        silence_req = 1'b1;
        tick();
        silence_req = 1'b0;
        #1;
        chk("t3_sil_busy", {31'd0, silence_busy}, 32'd1);
        nw = 0; bad = 1'b0; k = 0;
        while (silence_busy && k < 5000) begin
            if (s0_ready) bad = 1'b1;
            if (!opl_wr_n && nw < 16) begin
                if (!opl_a0) regs[nw] = opl_din;
                else begin
                    vals[nw] = opl_din;
                    nw++;
                end
            end
            tick();
            k++;
        end
        chk("t3_num_writes", nw, 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk("t3_sweep_reg", {24'd0, regs[i]}, (i < 9) ? 32'hB0 + i : 32'hBD);
            chk("t3_sweep_val", {24'd0, vals[i]}, 32'h00);
        end
        chk("t3_s0_held_off", {31'd0, bad}, 32'd0);
        chk("t3_s0_ready_after", {31'd0, s0_ready}, 32'd1);
        chk("t3_count", {16'd0, wr_count}, {16'd0, wc + 16'd11});
        s0_valid = 1'b0;

        // Abort during ADDR_GAP; lone s0 wins while pointer is on s1.
        wc = wr_count;
        s0_data = 16'h60AA; s0_valid = 1'b1;
        #1;
        chk("t4_lone_s0", {31'd0, s0_ready}, 32'd1);
        tick();
        s0_valid = 1'b0;
        tick(10);
        enable = 1'b0;
        tick();
        chk("t4_abort_wr_n", {31'd0, opl_wr_n}, 32'd1);
        chk("t4_abort_a0",   {31'd0, opl_a0}, 32'd0);
        chk("t4_abort_din",  {24'd0, opl_din}, 32'd0);
        chk("t4_abort_busy", {31'd0, busy}, 32'd0);
        s0_valid = 1'b1; s1_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!opl_wr_n || s0_ready || s1_ready) bad = 1'b1;
            tick();
        end
        chk("t4_held_idle", {31'd0, bad}, 32'd0);
        chk("t4_count_kept", {16'd0, wr_count}, {16'd0, wc});
        enable = 1'b1;
        #1;
        chk("t4_resume_s0", {31'd0, s0_ready}, 32'd1);
        chk("t4_resume_s1", {31'd0, s1_ready}, 32'd0);
        tick();
        s0_valid = 1'b0;
        chk("t4_resume_din", {24'd0, opl_din}, 32'h60);
        wait_grant(who);
        chk("t4_next_s1", who, 32'd1);
        tick();
        s1_valid = 1'b0;
        wait_idle("t4_idle");
        chk("t4_count", {16'd0, wr_count}, {16'd0, wc + 16'd2});

        // Reset in the middle of a silence sweep.
        silence_req = 1'b1;
        tick();
        silence_req = 1'b0;
        tick(400);
        chk("t5_sweep_running", {31'd0, silence_busy}, 32'd1);
        rst = 1'b1; s0_valid = 1'b1;
        tick();
        chk("t5_wr_n",     {31'd0, opl_wr_n}, 32'd1);
        chk("t5_a0",       {31'd0, opl_a0}, 32'd0);
        chk("t5_din",      {24'd0, opl_din}, 32'd0);
        chk("t5_s0_ready", {31'd0, s0_ready}, 32'd0);
        chk("t5_busy",     {31'd0, busy}, 32'd0);
        chk("t5_sil_busy", {31'd0, silence_busy}, 32'd0);
        chk("t5_count",    {16'd0, wr_count}, 32'd0);
        rst = 1'b0; s0_valid = 1'b0;
        tick(3);
        chk("t5_no_resume", {31'd0, silence_busy}, 32'd0);

        // Counter wrap from FFFF.
        force dut.r_wr_count = 16'hFFFF;
        tick();
        release dut.r_wr_count;
        tick();
        chk("t6_preset", {16'd0, wr_count}, 32'hFFFF);
        s0_data = 16'h0102; s0_valid = 1'b1;
        #1;
        tick();
        s0_valid = 1'b0;
        wait_idle("t6_idle");
        chk("t6_wrap", {16'd0, wr_count}, 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
